// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier with a per-operation signed/unsigned
//   mode. Operands are extended to WIDTH+1 bits, so one datapath covers both
//   modes exactly, including the most-negative and all-ones corner cases.
//   The operation takes WIDTH+1 iteration cycles and then one DONE cycle.
//   The product register holds its value until the next completed operation.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; busy=0, done=0
//   RUN   | one Booth step per cycle, WIDTH+1 steps; busy=1
//   DONE  | prod just updated; done=1 for one cycle; start here reloads
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   mc           multiplicand (sampled with start)
//   mp           multiplier   (sampled with start)
//   prod         registered 2*WIDTH-bit product of the last completed operation
//   busy         high while iterating
//   done         one-cycle pulse when prod is updated

module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       q_q, q_d;
    logic [WIDTH:0]       m_q, m_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH:0]       q_shift;
    logic [2*WIDTH+1:0]   aq_shift;
    logic [WIDTH:0]       mc_ext;
    logic [WIDTH:0]       mp_ext;

    // Extra top bit makes an unsigned operand look like a non-negative
    // signed value, so the same signed Booth recoding serves both modes.
    assign mc_ext = {signed_mode & mc[WIDTH-1], mc};
    assign mp_ext = {signed_mode & mp[WIDTH-1], mp};

    always_comb begin
        a_sum = a_q;
        unique case ({q_q[0], q1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
    end

    // Arithmetic right shift of {A,Q,Q_1}.
    assign a_shift  = {a_sum[WIDTH], a_sum[WIDTH:1]};
    assign q_shift  = {a_sum[0], q_q[WIDTH:1]};
    assign aq_shift = {a_shift, q_shift};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        count_d = count_q;
        prod_d  = prod_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = '0;
                    m_d     = mc_ext;
                    q_d     = mp_ext;
                    q1_d    = 1'b0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shift;
                q_d     = q_shift;
                q1_d    = q_q[0];
                count_d = count_q + CNT_ONE;
                if (count_q == LAST_STEP) begin
                    // The (WIDTH+1)x(WIDTH+1) product is exact in 2*WIDTH+2
                    // bits; the low 2*WIDTH bits are the true result.
                    prod_d  = aq_shift[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            prod_q  <= prod_d;
        end
    end

    assign prod = prod_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
